mano_seq_ctrl: RTL
==================

# mano_seq_ctrl

Timing and decode producer for the Mano basic computer control unit. Holds the start/stop flip-flop S, the 3-bit sequence counter SC, the instruction register IR and the indirect bit I. Drives the one-hot timing bus T, the decoded opcode bus D and the indirect flag J that every register-control block (AR, PC, DR, AC, IR, memory) consumes. Sits between the common bus and the per-register LD/CLR/INC logic.

## Interface
- `SC_W`, 3: sequence counter width.
- `T_N`, 6: number of timing outputs (T0..T5); must be ≤ 2**SC_W.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sets S; ignored while running.
- `halt`  in  1  clears S (HLT decode from downstream control).
- `sc_clr`  in  1  end-of-instruction; clears SC at the next edge.
- `bus_in`  in  16  common-bus value; captured into IR at the end of T1.
- `T`  out  T_N  one-hot timing; all zero when S=0.
- `D`  out  8  one-hot decode of IR[14:12].
- `J`  out  1  IR[15] (indirect bit).
- `ir`  out  16  IR contents.
- `running`  out  1  S flip-flop.
- `seq_err`  out  1  one-cycle pulse on an SC wrap without sc_clr.
- With `MANO_INTR_EN` only: `ien_set` in 1, `ien_clr` in 1, `fgi` in 1, `fgo` in 1, `ien` out 1, `r_cycle` out 1.

## Operation
- Reset, asynchronous and immediate, including mid-instruction: S=0, SC=0, IR=0, seq_err=0, IEN=0, R=0. Resulting outputs: T=0, D=8'h01, J=0, ir=0, running=0, r_cycle=0, ien=0.
- S: set by `start`, cleared by `halt`. `halt` wins if both are asserted.
- SC, applied only when S=1, in priority order:
  - `sc_clr` → 0.
  - SC = T_N-1 → 0, and `seq_err` pulses for one cycle.
  - Otherwise SC+1.
- SC is frozen while S=0. `halt` together with `sc_clr` gives S=0 and SC=0.
- T[k] = S & (SC==k). Combinational from registers, so no glitch across outputs.
- IR loads `bus_in` at the edge ending T1 when R=0.
- D and J are combinational from IR and valid from T2 until the next IR load.

## Timing
- `start` at edge n → running=1 and T0 from cycle n+1.
- Fetch: T0, T1 (IR captured at the T1/T2 edge), T2 with D and J valid.
- Execution runs T3.. until `sc_clr`. The next cycle is T0.
- Minimum instruction length is 4 cycles: sc_clr at T3.
- `halt` during Tk: T goes to 0 the next cycle. SC holds its value unless sc_clr was asserted with it.
- `seq_err` is registered. It is high in the cycle after the wrap, with T0 active.

## Configuration
- `MANO_INTR_EN` defined: interrupt support is compiled in.
  - IEN flip-flop: `ien_set` sets it, `ien_clr` clears it; clear wins.
  - R is set at an edge when S & IEN & (fgi|fgo) & ~(T0|T1|T2).
  - While R=1, T0..T2 form the interrupt cycle: r_cycle=1 and no IR load.
  - At the edge ending RT2, hardware clears R, IEN and SC.
- `MANO_INTR_EN` undefined: none of this logic or these ports exist. R is treated as constant 0.

## Structure
- Shared package `mano_pkg` holds:
  - IR field positions: I=15, OP=14:12, ADDR=11:0.
  - Opcode constant D7 = 3'b111.
  - SC_W and T_N defaults.
  - Word width 16.
- Sub-module `mano_dec3to8`: combinational 3-to-8 one-hot decoder for D. Reusable by the I/O and register-reference decode.

## Test plan
- Reset, then `start`:
  - T sequence 000001→000010→000100.
  - bus_in=16'hA123 presented in T1 gives ir=16'hA123, D=8'h04, J=1 in T2.
- sc_clr at T3 → T0 next cycle. Four-cycle loop repeats with no seq_err.
- No sc_clr through T5 → T0 next cycle with seq_err=1 for exactly one cycle.
- `halt` together with `sc_clr` at T4 → T=0, running=0, SC=0.
  - A later `start` resumes at T0.
  - `start` with `halt` in the same cycle leaves S=0.
- Async `rst` mid-T3 → all outputs at reset values before the next edge. D=8'h01.
- With `MANO_INTR_EN`:
  - ien_set, then fgi=1 during T3 → R set.
  - After sc_clr, three r_cycle cycles RT0..RT2 with no IR load.
  - Then ien=0, r_cycle=0, T0.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared definitions for the Mano basic computer control unit:
// instruction-register field positions, the D7 opcode, default
// sequence-counter geometry and the machine word width.
package mano_pkg;

    localparam int WORD_W     = 16;
    localparam int SC_W_DEF   = 3;
    localparam int T_N_DEF    = 6;

    localparam int IR_I       = 15;
    localparam int IR_OP_HI   = 14;
    localparam int IR_OP_LO   = 12;
    localparam int IR_ADDR_HI = 11;
    localparam int IR_ADDR_LO = 0;

    localparam logic [2:0] OP_D7 = 3'b111;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [2:0]        opcode_t;

    // Extract the 3-bit opcode field of an instruction word.
    function automatic opcode_t ir_opcode(input word_t w);
        return w[IR_OP_HI:IR_OP_LO];
    endfunction

endpackage

// File: rtl/mano_dec3to8.sv
// Combinational 3-to-8 one-hot decoder. Used for the opcode bus D and
// reusable by the register-reference and I/O decode blocks.
module mano_dec3to8
    import mano_pkg::*;
(
    input  logic [2:0] op_i,
    output logic [7:0] dec_o
);

    // Exactly one output bit high, selected by op_i.
    always_comb begin
        dec_o = 8'b0000_0001 << op_i;
    end

endmodule

// File: rtl/mano_seq_ctrl.sv
// Timing and decode producer for the Mano basic computer: start/stop
// flip-flop S, sequence counter SC, instruction register IR and the
// derived T (timing), D (opcode) and J (indirect) buses.
// Optional macro MANO_INTR_EN compiles in the IEN/R interrupt-cycle logic;
// without it R is a constant 0 and the interrupt ports do not exist.
module mano_seq_ctrl
    import mano_pkg::*;
#(
    parameter int SC_W = SC_W_DEF,
    parameter int T_N  = T_N_DEF      // must not exceed 2**SC_W, and at least 3
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              sc_clr,
    input  logic [WORD_W-1:0] bus_in,
`ifdef MANO_INTR_EN
    input  logic              ien_set,
    input  logic              ien_clr,
    input  logic              fgi,
    input  logic              fgo,
    output logic              ien,
    output logic              r_cycle,
`endif
    output logic [T_N-1:0]    T,
    output logic [7:0]        D,
    output logic              J,
    output logic [WORD_W-1:0] ir,
    output logic              running,
    output logic              seq_err
);

    logic              s_q, s_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic              seq_err_q, seq_err_d;

    logic              r_flag;     // interrupt-cycle flag R (0 when not built)
    logic              sc_last;    // SC sits on the last timing slot
    logic              rt2_end;    // current edge ends RT2 of an interrupt cycle

    // Timing outputs decode directly from registers so they never glitch.
    for (genvar k = 0; k < T_N; k++) begin : g_t
        assign T[k] = s_q && (sc_q == SC_W'(k));
    end

    assign sc_last = (sc_q == SC_W'(T_N - 1));
    assign rt2_end = r_flag && T[2];

    // Next-state for S, SC, IR and the wrap error pulse.
    always_comb begin
        s_d       = s_q;
        sc_d      = sc_q;
        ir_d      = ir_q;
        seq_err_d = 1'b0;

        if (halt) begin
            s_d = 1'b0;
        end else if (start) begin
            s_d = 1'b1;
        end

        // A halt without sc_clr freezes SC so the instruction can resume.
        if (s_q) begin
            if (sc_clr || rt2_end) begin
                sc_d = '0;
            end else if (!halt) begin
                if (sc_last) begin
                    sc_d      = '0;
                    seq_err_d = 1'b1;
                end else begin
                    sc_d = sc_q + SC_W'(1);
                end
            end
        end

        // Fetch captures the bus at the T1/T2 edge; interrupt cycles do not.
        if (T[1] && !r_flag) begin
            ir_d = bus_in;
        end
    end

    // Control and instruction state, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q       <= 1'b0;
            sc_q      <= '0;
            ir_q      <= '0;
            seq_err_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            sc_q      <= sc_d;
            ir_q      <= ir_d;
            seq_err_q <= seq_err_d;
        end
    end

`ifdef MANO_INTR_EN
    logic ien_q, ien_d;
    logic r_q, r_d;

    // IEN (clear wins) and R; R can only rise outside the fetch slots T0..T2.
    always_comb begin
        ien_d = ien_q;
        r_d   = r_q;

        if (ien_clr || rt2_end) begin
            ien_d = 1'b0;
        end else if (ien_set) begin
            ien_d = 1'b1;
        end

        if (rt2_end) begin
            r_d = 1'b0;
        end else if (s_q && ien_q && (fgi || fgo) && !(T[0] || T[1] || T[2])) begin
            r_d = 1'b1;
        end
    end

    // Interrupt enable and interrupt-cycle flip-flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien_q <= 1'b0;
            r_q   <= 1'b0;
        end else begin
            ien_q <= ien_d;
            r_q   <= r_d;
        end
    end

    assign r_flag  = r_q;
    assign ien     = ien_q;
    assign r_cycle = r_q;
`else
    assign r_flag  = 1'b0;
`endif

    mano_dec3to8 u_dec (
        .op_i  (ir_opcode(ir_q)),
        .dec_o (D)
    );

    assign J       = ir_q[IR_I];
    assign ir      = ir_q;
    assign running = s_q;
    assign seq_err = seq_err_q;

endmodule
